// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port controller for the external 1Mx16 asynchronous SRAM.
// Accepts one read or write request at a time from the level-sensitive
// reading/writing handshake, sequences the SRAM pins with parameterised wait
// states, holds the last read word, and pulses SRAM_done for one cycle when a
// transfer finishes. Every SRAM pin is driven straight from a flop.
module sram_ctrl #(
  parameter int unsigned READ_WAIT  = 2,  // cycles CE_N/OE_N stay low per read, 1..15
  parameter int unsigned WRITE_WAIT = 2   // cycles WE_N stays low per write, 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        reading,
  input  logic        writing,
  input  logic [19:0] ADDR,
  input  logic [15:0] DATA_WR,
  input  logic [1:0]  BE,
  output logic        SRAM_done,
  output logic [15:0] DATA_RD,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  inout  wire  [15:0] SRAM_DQ
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  // Terminal values of the shared wait counter in RD and WR_PULSE.
  localparam logic [3:0] RD_LAST = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q, rdata_d;

  // Registered pin levels; _d values are decoded from the next state so the
  // pins change on the same edge as the state they belong to.
  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic ub_n_q, ub_n_d;
  logic lb_n_q, lb_n_d;
  logic dq_oe_q, dq_oe_d;
  logic done_q, done_d;

  // Next-state, request capture, read-data capture and pin decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        // Read has priority when both requests are raised together.
        if (reading) begin
          addr_d  = ADDR;
          cnt_d   = 4'd0;
          state_d = S_RD;
        end else if (writing) begin
          addr_d  = ADDR;
          wdata_d = DATA_WR;
          be_d    = BE;
          cnt_d   = 4'd0;
          state_d = S_WR_SETUP;
        end
      end

      S_RD: begin
        // The SRAM has been driving DQ for READ_WAIT cycles by the last edge.
        if (cnt_q == RD_LAST) begin
          rdata_d = SRAM_DQ;
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WR_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_WR_PULSE;
      end

      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_WR_HOLD: state_d = S_DONE;

      S_DONE: state_d = S_IDLE;

      default: begin
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end
    endcase

    // Pin levels for the state about to be entered; idle levels by default.
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    done_d  = 1'b0;

    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end

      S_WR_SETUP, S_WR_HOLD: begin
        // Address and data are valid around the WE_N pulse for setup/hold.
        ce_n_d  = 1'b0;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        dq_oe_d = 1'b1;
      end

      S_WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        dq_oe_d = 1'b1;
      end

      S_DONE: done_d = 1'b1;

      default: ;
    endcase
  end

  // State, datapath and pin registers with synchronous active-high reset.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
      be_q    <= 2'b00;
      rdata_q <= 16'd0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
      done_q  <= done_d;
    end
  end

  // The data bus is driven only in the write states; high-Z otherwise, which
  // leaves IDLE and DONE as turnaround cycles between a write and a read.
  assign SRAM_DQ = dq_oe_q ? wdata_q : 16'hzzzz;

  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_done = done_q;
  assign DATA_RD   = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and randomized bench for sram_ctrl. An async SRAM
// device model sits on the pins; expected pin timing per cycle is derived from
// the wait-state rules, and expected data from a word array of SRAM contents.
module tb_sram_ctrl;

  localparam int RW = 2;
  localparam int WW = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        reading = 1'b0;
  logic        writing = 1'b0;
  logic [19:0] ADDR = 20'd0;
  logic [15:0] DATA_WR = 16'd0;
  logic [1:0]  BE = 2'b00;
  logic        SRAM_done;
  logic [15:0] DATA_RD;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
  wire  [15:0] SRAM_DQ;

  sram_ctrl #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .reading   (reading),
    .writing   (writing),
    .ADDR      (ADDR),
    .DATA_WR   (DATA_WR),
    .BE        (BE),
    .SRAM_done (SRAM_done),
    .DATA_RD   (DATA_RD),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_DQ   (SRAM_DQ)
  );

  always #5 Clk = ~Clk;

  // ---------------- SRAM device model (1K words visible) ----------------
  logic [15:0] sram_mem [0:1023];
  logic        fill = 1'b0;
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = 10'd0;
  logic [15:0] pl_data = 16'd0;

  // Undriven bus reads as all ones, so a floating bus is visible as 16'hFFFF.
  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (SRAM_DQ[g]);
  end

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram_mem[SRAM_ADDR[9:0]] : 16'hzzzz;

  always @(negedge Clk) begin
    if (fill) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= 16'(i * 40503 + 17);
    end else if (pl_en) begin
      sram_mem[pl_addr] <= pl_data;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[9:0]][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[9:0]][7:0]  <= SRAM_DQ[7:0];
    end
  end

  // ---------------- reference state ----------------
  logic [15:0] exp_mem [0:1023];
  logic [15:0] exp_rd = 16'd0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          last_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    cyc_n++;
  endtask

  function automatic logic [4:0] pins();
    return {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};
  endfunction

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(posedge Clk);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge Clk);
    pl_en   = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pins"}, 32'(pins()), 32'h1F);
    check({tag, "_done"}, 32'(SRAM_done), 32'h0);
    check({tag, "_dq"}, 32'(SRAM_DQ), 32'hFFFF);
    check({tag, "_rd"}, 32'(DATA_RD), 32'(exp_rd));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      check_idle("idle");
    end
  endtask

  // Issue a read in the current IDLE cycle and check every cycle up to DONE.
  // keep: hold reading through the transfer and drop it on seeing done.
  // both: raise writing together with reading.
  task automatic do_read(input logic [19:0] a, input bit keep, input bit both);
    reading = 1'b1;
    ADDR    = a;
    if (both) begin
      writing = 1'b1;
      DATA_WR = 16'($urandom);
      BE      = 2'b11;
    end
    for (int k = 1; k <= RW + 1; k++) begin
      cyc();
      if (k == 1) begin
        if (!keep) reading = 1'b0;
        writing = 1'b0;
        ADDR    = 20'($urandom);
        DATA_WR = 16'($urandom);
      end
      if (k <= RW) begin
        check("rd_pins", 32'(pins()), 32'h04);
        check("rd_addr", 32'(SRAM_ADDR), 32'(a));
        check("rd_done", 32'(SRAM_done), 32'h0);
        check("rd_hold", 32'(DATA_RD), 32'(exp_rd));
      end else begin
        exp_rd = exp_mem[a[9:0]];
        last_done = cyc_n;
        check("rd_end_pins", 32'(pins()), 32'h1F);
        check("rd_end_done", 32'(SRAM_done), 32'h1);
        check("rd_data", 32'(DATA_RD), 32'(exp_rd));
        check("rd_end_dq", 32'(SRAM_DQ), 32'hFFFF);
        if (keep) reading = 1'b0;
      end
    end
  endtask

  // Issue a write in the current IDLE cycle and check every cycle up to DONE.
  task automatic do_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [4:0] exp_pins;
    writing = 1'b1;
    ADDR    = a;
    DATA_WR = d;
    BE      = be;
    for (int k = 1; k <= WW + 3; k++) begin
      cyc();
      if (k == 1) begin
        writing = 1'b0;
        ADDR    = 20'($urandom);
        DATA_WR = 16'($urandom);
        BE      = 2'($urandom);
      end
      if (k <= WW + 2) begin
        // CE_N low, OE_N high, WE_N low only in the pulse cycles 2..WW+1.
        exp_pins = {1'b0, 1'b1, !(k >= 2 && k <= WW + 1), ~be[1], ~be[0]};
        check("wr_pins", 32'(pins()), 32'(exp_pins));
        check("wr_dq", 32'(SRAM_DQ), 32'(d));
        check("wr_addr", 32'(SRAM_ADDR), 32'(a));
        check("wr_done", 32'(SRAM_done), 32'h0);
      end else begin
        last_done = cyc_n;
        check("wr_end_pins", 32'(pins()), 32'h1F);
        check("wr_end_done", 32'(SRAM_done), 32'h1);
        check("wr_end_dq", 32'(SRAM_DQ), 32'hFFFF);
      end
      check("wr_rd_kept", 32'(DATA_RD), 32'(exp_rd));
    end
    if (be[1]) exp_mem[a[9:0]][15:8] = d[15:8];
    if (be[0]) exp_mem[a[9:0]][7:0]  = d[7:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc;
    int prev_done;

    // Device contents: a fixed pattern plus the directed preloads.
    @(posedge Clk);
    fill = 1'b1;
    @(posedge Clk);
    fill = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 16'(i * 40503 + 17);
    preload(10'h012, 16'hBEEF);
    preload(10'h040, 16'hFFFF);
    preload(10'h000, 16'h0001);
    preload(10'h001, 16'h0002);
    preload(10'h002, 16'h0003);
    preload(10'h003, 16'hFFFF);

    // Reset state.
    cyc();
    check_idle("reset");
    check("reset_addr", 32'(SRAM_ADDR), 32'h0);
    Reset = 1'b0;
    idle(5);

    // Directed read of 0x00012: done exactly RW+1 cycles after the request.
    start_cyc = cyc_n;
    do_read(20'h00012, 1'b0, 1'b0);
    check("rd_latency", 32'(last_done - start_cyc), 32'(RW + 1));
    check("rd_beef", 32'(DATA_RD), 32'hBEEF);
    idle(3);

    // Write 0x1234 to 0x00040 with lower byte only, over 0xFFFF.
    start_cyc = cyc_n;
    do_write(20'h00040, 16'h1234, 2'b01);
    check("wr_latency", 32'(last_done - start_cyc), 32'(WW + 3));
    idle(1);
    do_read(20'h00040, 1'b0, 1'b0);
    check("wr_merge", 32'(DATA_RD), 32'hFF34);
    idle(1);

    // Loader-style stream over addresses 0..3.
    prev_done = 0;
    for (int i = 0; i < 4; i++) begin
      do_read(20'(i), 1'b1, 1'b0);
      if (i > 0) check("stream_gap", 32'(last_done - prev_done), 32'(RW + 2));
      prev_done = last_done;
      idle(1);
    end
    check("stream_last", 32'(DATA_RD), 32'hFFFF);

    // Simultaneous read and write requests: read wins, memory untouched.
    do_read(20'h00012, 1'b0, 1'b1);
    idle(1);
    do_read(20'h00012, 1'b0, 1'b0);
    check("both_mem", 32'(DATA_RD), 32'hBEEF);
    idle(1);

    // Reset in the second RD cycle.
    reading = 1'b1;
    ADDR    = 20'h00001;
    cyc();
    reading = 1'b0;
    cyc();
    Reset = 1'b1;
    cyc();
    exp_rd = 16'h0000;
    check_idle("rst_rd");
    Reset = 1'b0;
    idle(1);

    // Reset in WR_PULSE after a read has loaded DATA_RD.
    do_read(20'h00002, 1'b0, 1'b0);
    idle(1);
    writing = 1'b1;
    ADDR    = 20'h003FF;
    DATA_WR = 16'hA55A;
    BE      = 2'b11;
    cyc();
    writing = 1'b0;
    cyc();
    check("rst_wr_pulse", 32'(SRAM_WE_N), 32'h0);
    Reset = 1'b1;
    cyc();
    exp_rd = 16'h0000;
    check_idle("rst_wr");
    Reset = 1'b0;
    idle(2);

    // Randomized mix of reads and writes against the word-array model.
    for (int t = 0; t < 40; t++) begin
      logic [19:0] a;
      a = 20'($urandom_range(0, 1022));
      if ($urandom_range(0, 1) == 0) do_read(a, 1'b0, 1'b0);
      else do_write(a, 16'($urandom), 2'($urandom));
      idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for the external 1M×16 asynchronous SRAM, and the responder end of the `reading`/`ADDR`/`SRAM_done` handshake used by the background loader and other SRAM clients. It accepts one read or write request at a time, drives the SRAM pins with parameterised wait states, captures read data into a holding register, and pulses `SRAM_done` for one cycle on completion. It sits between the SRAM clients and the board SRAM pins, all in the `Clk` domain.

## Interface
- `READ_WAIT`, default 2: cycles OE_N/CE_N are held low before read data is captured; legal 1..15.
- `WRITE_WAIT`, default 2: cycles WE_N is held low per write; legal 1..15.

- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `reading` in 1: read request, level; sampled only in IDLE.
- `writing` in 1: write request, level; sampled only in IDLE.
- `ADDR` in 20: word address; latched at request acceptance.
- `DATA_WR` in 16: write data; latched at request acceptance.
- `BE` in 2: write byte enables, [1]=upper, [0]=lower, active-high; latched with the write.
- `SRAM_done` out 1: one-cycle completion pulse.
- `DATA_RD` out 16: last captured read word; holds until the next read capture.
- `SRAM_ADDR` out 20: SRAM address pins.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: SRAM control pins, active-low.
- `SRAM_DQ` inout 16: SRAM data bus. Driven only during write states, high-Z otherwise.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. All pin outputs are registered.
- IDLE: all `_N` pins high, DQ high-Z, `SRAM_done`=0.
  - If `reading`=1, latch `ADDR` and go to RD. Read wins if both requests are high.
  - Else if `writing`=1, latch `ADDR`, `DATA_WR`, `BE` and go to WR_SETUP.
- RD:
  - CE_N=0, OE_N=0, UB_N=LB_N=0, WE_N=1, SRAM_ADDR=latched address.
  - A 4-bit counter runs READ_WAIT cycles. On the last cycle's edge, SRAM_DQ is registered into `DATA_RD` and the state goes to DONE.
- WR_SETUP (1 cycle): CE_N=0, WE_N=1, OE_N=1, DQ driven with latched data, UB_N/LB_N=~BE.
- WR_PULSE (WRITE_WAIT cycles): same as WR_SETUP but WE_N=0.
- WR_HOLD (1 cycle): WE_N=1, address and DQ still driven (hold time). Then go to DONE.
- DONE (1 cycle): `SRAM_done`=1, pins back to idle levels, DQ high-Z, requests ignored. Then go to IDLE.
- Requests are levels. A client that keeps `reading` high after DONE starts a new read at whatever `ADDR` shows in the IDLE cycle. The loader's one-cycle drop of `reading` (its write state) lands exactly on this IDLE cycle, and the new address is accepted on the following cycle.
- Changes to `ADDR`/`DATA_WR`/`BE` mid-transaction have no effect.
- `BE`=00 on a write still runs the full write cycle with UB_N=LB_N=1, so no bytes change.
- `DATA_RD` is not modified by writes.

## Timing
- Reset values: state IDLE; CE_N=OE_N=WE_N=UB_N=LB_N=1; SRAM_ADDR=0; DQ high-Z; `DATA_RD`=0; `SRAM_done`=0; counter 0.
- Reset mid-transaction aborts at the next edge: all pins return to reset levels, no `SRAM_done`, `DATA_RD` cleared.
- Read latency: request high in cycle n (state IDLE) → RD in cycles n+1..n+READ_WAIT → `SRAM_done`=1 with valid `DATA_RD` in cycle n+READ_WAIT+1. Default: done 3 cycles after request.
- Write latency: request in cycle n → `SRAM_done` in cycle n+WRITE_WAIT+3. Default: 5 cycles.
- Back-to-back minimum: the next request can be accepted in the cycle after DONE. Read-to-read period is READ_WAIT+2 cycles.
- DQ turnaround: the bus is high-Z in IDLE and DONE, so there is at least one undriven cycle between a write and a following read.

## Test plan
- Reset, then idle 5 cycles → all `_N` pins 1, DQ high-Z, `DATA_RD`=0, `SRAM_done` never 1.
- Preload model word 0x00012=0xBEEF; `reading`=1, `ADDR`=0x00012 in cycle 0 → OE_N/CE_N low in cycles 1–2, `SRAM_done`=1 only in cycle 3, `DATA_RD`=0xBEEF through the following idle cycles.
- Write 0x1234 to 0x00040 with BE=01, over prior 0xFFFF → WE_N low exactly 2 cycles, LB_N=0, UB_N=1, `SRAM_done` in cycle 5, memory reads back 0x FF34 (0xFF34).
- Loader-style stream: hold `reading`, drop it for one cycle after each `SRAM_done`, addresses 0..3 holding 0x0001,0x0002,0x0003,0xFFFF → four done pulses, 4 cycles apart, with matching `DATA_RD` values and correct addresses on SRAM_ADDR.
- `reading` and `writing` both high in IDLE → read is performed, WE_N stays 1 and DQ is never driven.
- Assert `Reset` in the second RD cycle, then in WR_PULSE → at the next edge all pins are 1, DQ high-Z, no `SRAM_done`, `DATA_RD`=0.
